// File: rtl/wormhole_route_unit_pkg.sv
// Shared constants for the wormhole route unit: direction codes, FSM states,
// flit-type bit positions and a helper for the coordinate field width.
package wormhole_route_unit_pkg;

  localparam int DIR_W       = 3;
  localparam int DEF_ADDR_SZ = 4;

  // Output direction codes; LOCAL doubles as the reset/default route.
  typedef enum logic [DIR_W-1:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    WEST  = 3'd2,
    NORTH = 3'd3,
    SOUTH = 3'd4
  } dir_e;

  // Wormhole lock state: IDLE waits for a head, LOCKED follows a packet body.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } route_state_e;

  // Flit-type bit positions when head/tail are carried as a 2-bit field.
  localparam int FLIT_TAIL_BIT = 0;
  localparam int FLIT_HEAD_BIT = 1;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_type_t;

  // Width of one coordinate field; never narrower than one bit so that a
  // 1x1 mesh still has a legal (constant-zero) coordinate.
  function automatic int coord_w(input int mesh_x, input int mesh_y);
    int m;
    m = (mesh_x > mesh_y) ? mesh_x : mesh_y;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/wormhole_route_unit_mesh_coord.sv
// Combinational node-id to mesh-coordinate conversion.
// x = id % MESH_X, y = id / MESH_X; out_of_range flags ids past the last node.
module mesh_coord
  import wormhole_route_unit_pkg::*;
#(
  parameter int MESH_X  = 3,
  parameter int MESH_Y  = 3,
  parameter int ADDR_SZ = DEF_ADDR_SZ,
  parameter int CW      = coord_w(MESH_X, MESH_Y)
) (
  input  logic [ADDR_SZ-1:0] id,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               out_of_range
);

  logic [31:0] id_ext;
  logic [31:0] x_full;
  logic [31:0] y_full;

  // Divide the id into column/row; y is only meaningful when in range.
  always_comb begin
    id_ext       = 32'(id);
    x_full       = id_ext % 32'(MESH_X);
    y_full       = id_ext / 32'(MESH_X);
    out_of_range = (id_ext >= 32'(MESH_X * MESH_Y));
    x            = CW'(x_full);
    y            = CW'(y_full);
  end

endmodule

// File: rtl/wormhole_route_unit.sv
// Wormhole route unit: computes a dimension-order output direction from the
// head flit, locks it for the rest of the packet and forwards every flit
// through a single valid/ready register stage.
module wormhole_route_unit
  import wormhole_route_unit_pkg::*;
#(
  parameter int MESH_X   = 3,
  parameter int MESH_Y   = 3,
  parameter int ADDR_SZ  = 4,
  parameter int BITS_DIR = 3,
  parameter int DATA_W   = 32,
  parameter int YX_MODE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_SZ-1:0]  local_id,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_head,
  input  logic                in_tail,
  input  logic [ADDR_SZ-1:0]  in_dest,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS_DIR-1:0] out_dir,
  output logic                out_head,
  output logic                out_tail,
  output logic [DATA_W-1:0]   out_data,
  output logic                route_err
);

  localparam int CW = coord_w(MESH_X, MESH_Y);

  localparam logic [BITS_DIR-1:0] D_LOCAL = BITS_DIR'(LOCAL);
  localparam logic [BITS_DIR-1:0] D_EAST  = BITS_DIR'(EAST);
  localparam logic [BITS_DIR-1:0] D_WEST  = BITS_DIR'(WEST);
  localparam logic [BITS_DIR-1:0] D_NORTH = BITS_DIR'(NORTH);
  localparam logic [BITS_DIR-1:0] D_SOUTH = BITS_DIR'(SOUTH);

  logic [CW-1:0] loc_x, loc_y, dst_x, dst_y;
  logic          loc_oor, dst_oor;
  logic          loc_oor_unused;

  route_state_e        state_p0, state_nxt;
  logic [BITS_DIR-1:0] route_reg, route_nxt;
  logic [BITS_DIR-1:0] head_dir;
  logic [BITS_DIR-1:0] dir_nxt;
  logic                err_nxt;
  logic                accept;

  logic                vld_p0;
  logic [BITS_DIR-1:0] dir_p0;
  logic                head_p0;
  logic                tail_p0;
  logic [DATA_W-1:0]   data_p0;
  logic                err_p0;

  mesh_coord #(
    .MESH_X (MESH_X),
    .MESH_Y (MESH_Y),
    .ADDR_SZ(ADDR_SZ),
    .CW     (CW)
  ) u_loc_coord (
    .id          (local_id),
    .x           (loc_x),
    .y           (loc_y),
    .out_of_range(loc_oor)
  );

  mesh_coord #(
    .MESH_X (MESH_X),
    .MESH_Y (MESH_Y),
    .ADDR_SZ(ADDR_SZ),
    .CW     (CW)
  ) u_dst_coord (
    .id          (in_dest),
    .x           (dst_x),
    .y           (dst_y),
    .out_of_range(dst_oor)
  );

  // A misconfigured local_id is not flagged; the router id is trusted.
  assign loc_oor_unused = loc_oor;

  // Dimension-order route: resolve one axis completely before the other.
  // On a degenerate axis both coordinates are always zero, so that axis
  // never produces a move.
  function automatic logic [BITS_DIR-1:0] route_calc(
    input logic [CW-1:0] xl,
    input logic [CW-1:0] yl,
    input logic [CW-1:0] xd,
    input logic [CW-1:0] yd
  );
    logic [BITS_DIR-1:0] d;
    d = D_LOCAL;
    if (YX_MODE == 0) begin
      if (xd > xl)      d = D_EAST;
      else if (xd < xl) d = D_WEST;
      else if (yd > yl) d = D_SOUTH;
      else if (yd < yl) d = D_NORTH;
    end else begin
      if (yd > yl)      d = D_SOUTH;
      else if (yd < yl) d = D_NORTH;
      else if (xd > xl) d = D_EAST;
      else if (xd < xl) d = D_WEST;
    end
    return d;
  endfunction

  // The stage accepts whenever its register is empty or being drained.
  assign in_ready = !vld_p0 || out_ready;
  assign accept   = in_valid && in_ready;
  assign head_dir = dst_oor ? D_LOCAL : route_calc(loc_x, loc_y, dst_x, dst_y);

  // Next-state, locked route and error decision for the flit being accepted.
  always_comb begin
    state_nxt = state_p0;
    route_nxt = route_reg;
    dir_nxt   = route_reg;
    err_nxt   = 1'b0;
    if (accept) begin
      if (in_head) begin
        // A head always (re)computes the route; a head that interrupts a
        // locked packet is still honoured but flagged.
        dir_nxt   = head_dir;
        route_nxt = head_dir;
        err_nxt   = dst_oor || (state_p0 == LOCKED);
        state_nxt = in_tail ? IDLE : LOCKED;
      end else begin
        // Body/tail reuse the locked route; with no packet open it is an
        // orphan flit, forwarded on the stale route and flagged.
        dir_nxt = route_reg;
        err_nxt = (state_p0 == IDLE);
        if ((state_p0 == LOCKED) && in_tail) state_nxt = IDLE;
      end
    end
  end

  // Wormhole lock state and the route held for the open packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      route_reg <= D_LOCAL;
    end else begin
      state_p0  <= state_nxt;
      route_reg <= route_nxt;
    end
  end

  // ---- stage p0: output register, loads on accept and holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      dir_p0  <= D_LOCAL;
      head_p0 <= 1'b0;
      tail_p0 <= 1'b0;
      data_p0 <= '0;
      err_p0  <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      dir_p0  <= dir_nxt;
      head_p0 <= in_head;
      tail_p0 <= in_tail;
      data_p0 <= in_data;
      err_p0  <= err_nxt;
    end else begin
      if (out_ready) vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_dir   = dir_p0;
  assign out_head  = head_p0;
  assign out_tail  = tail_p0;
  assign out_data  = data_p0;
  assign route_err = err_p0;

endmodule

// File: doc/wormhole_route_unit.md
Name: wormhole_route_unit

Overview:
- Parametrised successor of the combinational mesh routing table.
- One instance sits at each router input port, between the input buffer and the switch allocator.
- Computes the output direction once per packet, from the head flit, using dimension-order routing (XY or YX) on a MESH_X by MESH_Y mesh.
- Locks that direction for all body and tail flits of the packet (wormhole) and presents each flit one cycle later through a valid/ready register stage.

Parameters:
- MESH_X, 3: mesh columns, 1..16.
- MESH_Y, 3: mesh rows, 1..16.
- ADDR_SZ, 4: node-id width; must satisfy 2^ADDR_SZ >= MESH_X*MESH_Y.
- BITS_DIR, 3: direction-code width.
- DATA_W, 32: payload width.
- YX_MODE, 0: 0 = XY order (X resolved first); 1 = YX order.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- local_id, in, ADDR_SZ: this router's node id; quasi-static.
- in_valid, in, 1: input flit valid.
- in_ready, out, 1: unit can accept a flit.
- in_head, in, 1: flit is a packet head.
- in_tail, in, 1: flit is a packet tail (head and tail both set = single-flit packet).
- in_dest, in, ADDR_SZ: destination id; sampled only on head flits.
- in_data, in, DATA_W: payload.
- out_valid, out, 1: output flit valid.
- out_ready, in, 1: downstream accepts.
- out_dir, out, BITS_DIR: routed direction (EAST/WEST/NORTH/SOUTH/LOCAL codes).
- out_head, out, 1: registered copy of in_head.
- out_tail, out, 1: registered copy of in_tail.
- out_data, out, DATA_W: registered payload.
- route_err, out, 1: one-cycle error pulse.

Behaviour:
- Only one clock (clk); reset is synchronous, active-high (rst).
- Reset values: out_valid=0, out_dir=LOCAL, out_head=0, out_tail=0, out_data=0, route_err=0, FSM=IDLE, route_reg=LOCAL.
- Coordinates: x = id % MESH_X, y = id / MESH_X.
- Direction rules, XY order:
  - x_dest>x_loc -> EAST; x_dest<x_loc -> WEST
  - else y_dest>y_loc -> SOUTH; y_dest<y_loc -> NORTH
  - else LOCAL
- YX order: compare y first, then x.
- All comparisons are unsigned on coordinate fields of width clog2(max(MESH_X,MESH_Y)).
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational.
  - Latency is exactly 1 cycle from acceptance to out_valid.
  - Output register holds stable while out_valid && !out_ready.
  - Full throughput (one flit per cycle) when out_ready is held high.
- FSM states:
  - IDLE --accepted head, !tail--> LOCKED
  - IDLE --accepted head&tail--> IDLE
  - LOCKED --accepted tail--> IDLE
  - Otherwise the FSM holds its state.
- Head flit: route computed from in_dest and written to route_reg and out_dir in the same edge.
- Body/tail flit: out_dir = route_reg; in_dest is ignored.
- Error cases:
  - Out-of-range destination (in_dest >= MESH_X*MESH_Y on a head): out_dir=LOCAL, route_err=1 for one cycle; flit still forwarded and FSM still advances.
  - Body/tail flit accepted in IDLE: flit forwarded with out_dir=route_reg, route_err pulses, FSM stays IDLE.
  - Head flit accepted in LOCKED: treated as a new packet (route recomputed, relock), route_err pulses.
- route_err is registered and aligned with the offending flit's out_valid cycle.
- Reset mid-packet returns the FSM to IDLE and drops the held output flit (out_valid=0 the next cycle).
- local_id change while LOCKED does not alter route_reg.
- Degenerate mesh (MESH_X=1 or MESH_Y=1): that dimension never yields EAST/WEST or NORTH/SOUTH respectively.

Decomposition:
- Shared constants package: direction codes EAST, WEST, NORTH, SOUTH, LOCAL (BITS_DIR wide), ADDR_SZ, flit-type bits.
- Sub-module mesh_coord (parameters MESH_X, MESH_Y, ADDR_SZ): combinational id -> (x, y, out_of_range). Instantiated twice, for local_id and in_dest.
- Top level holds the compare logic, FSM, route_reg and output register stage.

Test Plan:
- 3x3 XY, local_id=4, single-flit packet to dest 2 -> out_dir=EAST one cycle after acceptance. Same with YX_MODE=1 -> NORTH. Dest 4 -> LOCAL.
- local_id=0, head dest 8, then 2 body flits, then tail, all with in_dest=3 -> all four flits out_dir=EAST; FSM back in IDLE after the tail; route_err stays 0.
- Backpressure: out_ready low for 3 cycles while head is held -> in_ready=0, out_data/out_dir stable; release -> 4-flit packet streams at 1 flit/cycle.
- Head dest=9 on a 3x3 mesh -> out_dir=LOCAL, route_err=1 for exactly one cycle. Body flit in IDLE -> route_err pulse. Head in LOCKED -> relock to the new destination.
- rst asserted after a head (FSM=LOCKED, out_valid=1) -> next cycle out_valid=0, FSM=IDLE. A following body flit flags route_err.
- 4x2 mesh parameters, local_id=5 (1,1), dest 3 (3,0) -> EAST (XY) and NORTH (YX). Dest 7 -> 7 < 8, so in range -> EAST, no error.
